player_position_ctrl: RTL and testbench

- Upstream stage of the player bitmap ROM in the Circus-Charlie video path.
- Owns the player's on-screen position: per-frame horizontal walking and a ballistic jump state machine.
- Per pixel, turns the VGA scan coordinate into the registered offsetX/offsetY/InsideRectangle triple that the bitmap stage consumes.

---
 rtl/player_position_ctrl.sv | 150 +++++++++++++++
 tb/tb_player_position_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_position_ctrl.sv
// Player position controller: per-frame walking and ballistic jump, plus the
// registered sprite-rectangle stage that feeds the player bitmap ROM.
`timescale 1ns/1ps
module player_position_ctrl #(
    parameter int OBJECT_WIDTH_X = 32,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int START_X = 64,
    parameter int GROUND_Y = 400,
    parameter int X_MIN = 0,
    parameter int X_MAX = 608,
    parameter int X_SPEED = 2,
    parameter int JUMP_SPEED = 12,
    parameter int GRAVITY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        leftKey,
    input  logic        rightKey,
    input  logic        jumpKey,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        airborne
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AIR  = 2'd1,
        LAND = 2'd2
    } state_t;

    localparam logic signed [11:0] X_MIN_S    = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S    = 12'(X_MAX);
    localparam logic signed [11:0] X_SPEED_S  = 12'(X_SPEED);
    localparam logic signed [11:0] GROUND_S   = 12'(GROUND_Y);
    localparam logic signed [7:0]  VY_LAUNCH  = 8'(-JUMP_SPEED);
    localparam logic signed [7:0]  VY_GRAVITY = 8'(GRAVITY);
    localparam logic [11:0]        WIDTH_U    = 12'(OBJECT_WIDTH_X);
    localparam logic [11:0]        HEIGHT_U   = 12'(OBJECT_HEIGHT_Y);

    state_t            state;
    logic signed [7:0] vy;

    // Walk one step in the requested direction, saturating at the play-field
    // edges. The 12-bit signed intermediate keeps x - speed from wrapping at 0.
    function automatic logic [10:0] walk_sat(input logic [10:0] x,
                                             input logic left,
                                             input logic right);
        logic signed [11:0] xs;
        logic signed [11:0] nx;
        xs = signed'({1'b0, x});
        nx = xs;
        if (right && !left) begin
            nx = xs + X_SPEED_S;
            if (nx > X_MAX_S) nx = X_MAX_S;
        end else if (left && !right) begin
            nx = xs - X_SPEED_S;
            if (nx < X_MIN_S) nx = X_MIN_S;
        end
        return nx[10:0];
    endfunction

    function automatic logic signed [11:0] fall_y(input logic [10:0] y,
                                                  input logic signed [7:0] v);
        logic signed [11:0] ys;
        logic signed [11:0] vs;
        ys = signed'({1'b0, y});
        vs = {{4{v[7]}}, v};
        return ys + vs;
    endfunction

    logic signed [11:0] next_y_p0;
    assign next_y_p0 = fall_y(topLeftY, vy);

    // ---- frame-rate motion: position, velocity and jump state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            topLeftX <= 11'(START_X);
            topLeftY <= 11'(GROUND_Y);
            vy       <= '0;
            state    <= IDLE;
            airborne <= 1'b0;
        end else if (startOfFrame) begin
            topLeftX <= walk_sat(topLeftX, leftKey, rightKey);
            case (state)
                IDLE: begin
                    if (jumpKey) begin
                        vy       <= VY_LAUNCH;
                        state    <= AIR;
                        airborne <= 1'b1;
                    end
                end
                AIR: begin
                    if (next_y_p0 >= GROUND_S) begin
                        topLeftY <= 11'(GROUND_Y);
                        vy       <= '0;
                        state    <= LAND;
                        airborne <= 1'b0;
                    end else begin
                        topLeftY <= next_y_p0[10:0];
                        vy       <= vy + VY_GRAVITY;
                    end
                end
                LAND: begin
                    state    <= IDLE;
                    airborne <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    airborne <= 1'b0;
                end
            endcase
        end
    end

    logic [11:0] px_p0;
    logic [11:0] py_p0;
    logic [11:0] x_lo_p0;
    logic [11:0] y_lo_p0;
    logic        inside_p0;

    assign px_p0   = {1'b0, pixelX};
    assign py_p0   = {1'b0, pixelY};
    assign x_lo_p0 = {1'b0, topLeftX};
    assign y_lo_p0 = {1'b0, topLeftY};

    // Compares against the current (pre-update) position, so a pixel sampled
    // on a startOfFrame cycle still sees the old sprite box.
    assign inside_p0 = (px_p0 >= x_lo_p0) && (px_p0 < x_lo_p0 + WIDTH_U) &&
                       (py_p0 >= y_lo_p0) && (py_p0 < y_lo_p0 + HEIGHT_U);

    // ---- pixel-rate rectangle stage, one cycle of latency ----
    always_ff @(posedge clk) begin
        if (reset) begin
            offsetX         <= '0;
            offsetY         <= '0;
            InsideRectangle <= 1'b0;
        end else begin
            InsideRectangle <= inside_p0;
            offsetX         <= inside_p0 ? (pixelX - topLeftX) : 11'd0;
            offsetY         <= inside_p0 ? (pixelY - topLeftY) : 11'd0;
        end
    end

endmodule

// File: tb/tb_player_position_ctrl.sv
// Self-checking bench for player_position_ctrl: closed-form trajectory model
// compared every cycle, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_player_position_ctrl;

    localparam int W      = 32;
    localparam int H      = 32;
    localparam int SX     = 64;
    localparam int GROUND = 400;
    localparam int XMIN   = 0;
    localparam int XMAX   = 608;
    localparam int SPD    = 2;
    localparam int JS     = 12;
    localparam int G      = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        leftKey;
    logic        rightKey;
    logic        jumpKey;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        airborne;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    player_position_ctrl dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .pixelX(pixelX),
        .pixelY(pixelY),
        .leftKey(leftKey),
        .rightKey(rightKey),
        .jumpKey(jumpKey),
        .offsetX(offsetX),
        .offsetY(offsetY),
        .InsideRectangle(InsideRectangle),
        .topLeftX(topLeftX),
        .topLeftY(topLeftY),
        .airborne(airborne)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Height above ground after n airborne frames, from launch speed and gravity.
    function automatic int lift(input int n);
        return n * JS - (n * (n - 1) / 2) * G;
    endfunction

    function automatic int walk(input int x, input bit l, input bit r);
        if (r && !l) return (x + SPD > XMAX) ? XMAX : x + SPD;
        if (l && !r) return (x - SPD < XMIN) ? XMIN : x - SPD;
        return x;
    endfunction

    function automatic bit in_box(input int px, input int py, input int x, input int y);
        return (px >= x) && (px < x + W) && (py >= y) && (py < y + H);
    endfunction

    int m_x = SX, m_y = GROUND, m_jf = 0;
    bit m_air = 0, m_land = 0;
    int e_ox = 0, e_oy = 0;
    bit e_in = 0;
    bit chk_en = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_x <= SX; m_y <= GROUND; m_jf <= 0; m_air <= 0; m_land <= 0;
            e_ox <= 0; e_oy <= 0; e_in <= 0;
            chk_en <= 1;
        end else begin
            e_in <= in_box(int'(pixelX), int'(pixelY), m_x, m_y);
            e_ox <= in_box(int'(pixelX), int'(pixelY), m_x, m_y) ? int'(pixelX) - m_x : 0;
            e_oy <= in_box(int'(pixelX), int'(pixelY), m_x, m_y) ? int'(pixelY) - m_y : 0;
            if (startOfFrame) begin
                m_x <= walk(m_x, leftKey, rightKey);
                if (m_air) begin
                    if (GROUND - lift(m_jf + 1) >= GROUND) begin
                        m_y <= GROUND; m_air <= 0; m_land <= 1; m_jf <= 0;
                    end else begin
                        m_y <= GROUND - lift(m_jf + 1); m_jf <= m_jf + 1;
                    end
                end else if (m_land) begin
                    m_land <= 0;
                end else if (jumpKey) begin
                    m_air <= 1; m_jf <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("offsetX", int'(offsetX), e_ox);
            check("offsetY", int'(offsetY), e_oy);
            check("InsideRectangle", int'(InsideRectangle), int'(e_in));
            check("topLeftX", int'(topLeftX), m_x);
            check("topLeftY", int'(topLeftY), m_y);
            check("airborne", int'(airborne), int'(m_air));
        end
    end

    task automatic drive(input bit rst, input bit sof, input int px, input int py,
                         input bit l, input bit r, input bit j);
        reset = rst; startOfFrame = sof;
        pixelX = 11'(px); pixelY = 11'(py);
        leftKey = l; rightKey = r; jumpKey = j;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic frame(input bit l, input bit r, input bit j);
        drive(0, 1, 0, 0, l, r, j);
        drive(0, 0, 0, 0, l, r, j);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    int air_frames;

    initial begin
        reset = 1; startOfFrame = 0; pixelX = 0; pixelY = 0;
        leftKey = 0; rightKey = 0; jumpKey = 0;

        // reset state
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 64, 400, 0, 0, 0);
        check("rst_x", int'(topLeftX), 64);
        check("rst_y", int'(topLeftY), 400);
        check("rst_in", int'(InsideRectangle), 0);
        check("rst_air", int'(airborne), 0);

        // rectangle corners and edges
        drive(0, 0, 64, 400, 0, 0, 0);
        check("tl_in", int'(InsideRectangle), 1);
        check("tl_ox", int'(offsetX), 0);
        check("tl_oy", int'(offsetY), 0);
        drive(0, 0, 96, 400, 0, 0, 0);
        check("right_edge_in", int'(InsideRectangle), 0);
        check("right_edge_ox", int'(offsetX), 0);
        drive(0, 0, 95, 431, 0, 0, 0);
        check("br_in", int'(InsideRectangle), 1);
        check("br_ox", int'(offsetX), 31);
        check("br_oy", int'(offsetY), 31);
        drive(0, 0, 63, 410, 0, 0, 0);
        check("left_out", int'(InsideRectangle), 0);
        drive(0, 0, 70, 432, 0, 0, 0);
        check("bottom_out", int'(InsideRectangle), 0);
        drive(0, 0, 80, 399, 0, 0, 0);
        check("top_out", int'(InsideRectangle), 0);

        // walking right, left with clamp at 0, both keys, clamp at X_MAX
        for (int i = 0; i < 10; i++) frame(0, 1, 0);
        check("right10", int'(topLeftX), 84);
        do_reset();
        for (int i = 0; i < 32; i++) frame(1, 0, 0);
        check("left32", int'(topLeftX), 0);
        for (int i = 0; i < 8; i++) frame(1, 0, 0);
        check("left40", int'(topLeftX), 0);
        for (int i = 0; i < 3; i++) frame(1, 1, 0);
        check("both_keys", int'(topLeftX), 0);
        for (int i = 0; i < 304; i++) frame(0, 1, 0);
        check("right_max", int'(topLeftX), 608);
        frame(0, 1, 0);
        frame(0, 1, 0);
        check("right_clamp", int'(topLeftX), 608);

        // single jump pulse
        do_reset();
        air_frames = 0;
        frame(0, 0, 1);
        check("launch_y", int'(topLeftY), 400);
        if (airborne) air_frames++;
        for (int f = 1; f <= 26; f++) begin
            frame(0, 0, 0);
            if (airborne) air_frames++;
            if (f == 1)  check("jump_f1", int'(topLeftY), 388);
            if (f == 12) check("jump_f12", int'(topLeftY), 322);
            if (f == 13) check("jump_f13", int'(topLeftY), 322);
            if (f == 25) begin
                check("jump_f25_y", int'(topLeftY), 400);
                check("jump_f25_air", int'(airborne), 0);
            end
        end
        check("air_frames", air_frames, 25);

        // jump held: one LAND frame without re-jump, then re-launch
        do_reset();
        frame(0, 0, 1);
        for (int f = 1; f <= 25; f++) frame(0, 0, 1);
        check("held_land_air", int'(airborne), 0);
        check("held_land_y", int'(topLeftY), 400);
        frame(0, 0, 1);
        check("held_hold_air", int'(airborne), 0);
        frame(0, 0, 1);
        check("held_relaunch", int'(airborne), 1);

        // reset during a jump, walking right meanwhile
        do_reset();
        frame(0, 1, 1);
        for (int f = 1; f <= 5; f++) frame(0, 1, 0);
        check("mid_y", int'(topLeftY), 350);
        check("mid_x", int'(topLeftX), 76);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("midrst_y", int'(topLeftY), 400);
        check("midrst_x", int'(topLeftX), 64);
        check("midrst_air", int'(airborne), 0);
        for (int f = 0; f < 4; f++) frame(0, 0, 0);
        check("post_rst_y", int'(topLeftY), 400);
        check("post_rst_air", int'(airborne), 0);
        frame(0, 0, 1);
        frame(0, 0, 0);
        check("post_rst_jump", int'(topLeftY), 388);

        // pixel sampled on the frame-update cycle sees the old position
        do_reset();
        drive(0, 1, 64, 400, 0, 1, 0);
        check("coinc_in", int'(InsideRectangle), 1);
        check("coinc_ox", int'(offsetX), 0);
        check("coinc_newx", int'(topLeftX), 66);
        drive(0, 0, 64, 400, 0, 1, 0);
        check("after_in", int'(InsideRectangle), 0);
        check("after_ox", int'(offsetX), 0);
        drive(0, 0, 66, 400, 0, 0, 0);
        check("newtl_in", int'(InsideRectangle), 1);
        check("newtl_ox", int'(offsetX), 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
